// File: rtl/cp0_pkg.sv
// cp0_pkg: register numbers, exception codes and bit-field positions for the coprocessor-0 slice
package cp0_pkg;
  localparam logic [4:0] REG_SR = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC = 5'd14;
  localparam logic [4:0] REG_PRID = 5'd15;
  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYSCALL = 5'd8;
  localparam logic [4:0] EXC_RI = 5'd10;
  localparam logic [4:0] EXC_OV = 5'd12;
  localparam int SR_IE = 0;
  localparam int SR_EXL = 1;
  localparam int IM_LO = 10;
  localparam int IM_HI = 15;
  localparam int CAUSE_BD = 31;
  localparam int EXC_LO = 2;
  localparam int EXC_HI = 6;
endpackage

// File: rtl/cp0_exc_arbiter.sv
// cp0_exc_arbiter: decides whether an interrupt or exception is taken and what gets recorded
module cp0_exc_arbiter
  import cp0_pkg::*;
(
  input  logic        ie_i,
  input  logic        exl_i,
  input  logic [5:0]  im_i,
  input  logic [5:0]  hw_int_i,
  input  logic [4:0]  exc_code_i,
  input  logic        bd_i,
  input  logic [31:0] vpc_i,
  output logic        req_o,
  output logic [4:0]  exc_code_o,
  output logic [31:0] epc_o
);
  logic int_req, exc_req;
  assign int_req = ie_i & ~exl_i & |(im_i & hw_int_i);
  assign exc_req = (exc_code_i != 5'd0) & ~exl_i;
  assign req_o = int_req | exc_req;
  // interrupts win over a simultaneous exception
  assign exc_code_o = int_req ? EXC_INT : exc_code_i;
  assign epc_o = bd_i ? vpc_i - 32'd4 : vpc_i;
endmodule

// File: rtl/cp0_unit.sv
// cp0_unit: CP0 register file (SR, Cause, EPC, PRId) with exception/interrupt entry and eret support
module cp0_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID = 32'h2023_0707,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        WE,
  input  logic [31:0] VPC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic        EXLClr,
  input  logic [5:0]  HWInt,
  output logic        Req,
  output logic [31:0] NPCOut,
  output logic [31:0] EPCOut,
  output logic [31:0] DOut
);
  logic        ie_q, ie_d, exl_q, exl_d, bd_q, bd_d;
  logic [5:0]  im_q, im_d, ip_q, ip_d;
  logic [4:0]  exc_code_q, exc_code_d, sel_code;
  logic [31:0] epc_q, epc_d, sel_epc, sr, cause;

  cp0_exc_arbiter u_arb (
    .ie_i(ie_q), .exl_i(exl_q), .im_i(im_q), .hw_int_i(HWInt),
    .exc_code_i(ExcCodeIn), .bd_i(BDIn), .vpc_i(VPC),
    .req_o(Req), .exc_code_o(sel_code), .epc_o(sel_epc)
  );

  always_comb begin
    ie_d = ie_q;
    exl_d = exl_q;
    im_d = im_q;
    bd_d = bd_q;
    exc_code_d = exc_code_q;
    epc_d = epc_q;
    ip_d = HWInt;
    if (Req) begin
      exl_d = 1'b1;
      exc_code_d = sel_code;
      bd_d = BDIn;
      epc_d = sel_epc;
    end else begin
      if (WE && A2 == REG_SR) begin
        im_d = DIn[IM_HI:IM_LO];
        exl_d = DIn[SR_EXL];
        ie_d = DIn[SR_IE];
      end
      if (WE && A2 == REG_EPC) epc_d = DIn;
      // eret overrides a same-cycle mtc0 for the EXL bit
      if (EXLClr) exl_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ie_q <= 1'b0;
      exl_q <= 1'b0;
      im_q <= '0;
      bd_q <= 1'b0;
      ip_q <= '0;
      exc_code_q <= '0;
      epc_q <= '0;
    end else begin
      ie_q <= ie_d;
      exl_q <= exl_d;
      im_q <= im_d;
      bd_q <= bd_d;
      ip_q <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q <= epc_d;
    end
  end

  assign sr = {16'd0, im_q, 8'd0, exl_q, ie_q};
  assign cause = {bd_q, 15'd0, ip_q, 3'd0, exc_code_q, 2'd0};
  assign EPCOut = (WE && A2 == REG_EPC && !Req) ? DIn : epc_q;
  assign NPCOut = Req ? HANDLER_PC : epc_q;
  assign DOut = A1 == REG_SR ? sr : A1 == REG_CAUSE ? cause : A1 == REG_EPC ? epc_q :
                A1 == REG_PRID ? PRID : 32'd0;
endmodule

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit: directed scenario tests for cp0_unit with hand-computed expectations
module tb_cp0_unit;
  logic clk = 1'b0, reset = 1'b0, WE = 1'b0, BDIn = 1'b0, EXLClr = 1'b0, Req;
  logic [4:0] A1 = '0, A2 = '0, ExcCodeIn = '0;
  logic [5:0] HWInt = '0;
  logic [31:0] DIn = '0, VPC = '0, NPCOut, EPCOut, DOut;
  int pass = 0, tot = 0;

  cp0_unit dut (
    .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn), .WE(WE), .VPC(VPC),
    .BDIn(BDIn), .ExcCodeIn(ExcCodeIn), .EXLClr(EXLClr), .HWInt(HWInt),
    .Req(Req), .NPCOut(NPCOut), .EPCOut(EPCOut), .DOut(DOut)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a);
    A1 = a;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    WE = 1'b1; A2 = 5'd14; DIn = 32'hDEAD_BEEF; step();
    A2 = 5'd12; DIn = 32'h0000_FC03; step();
    WE = 1'b0; reset = 1'b0; step(); step();
    rd(5'd12); tot++; if (DOut !== 32'h0) $display("FAIL rst_sr got %h exp %h", DOut, 32'h0); else pass++;
    rd(5'd13); tot++; if (DOut !== 32'h0) $display("FAIL rst_cause got %h exp %h", DOut, 32'h0); else pass++;
    rd(5'd14); tot++; if (DOut !== 32'h0) $display("FAIL rst_epc got %h exp %h", DOut, 32'h0); else pass++;
    tot++; if (Req !== 1'b0) $display("FAIL rst_req got %b exp 0", Req); else pass++;
    tot++; if (EPCOut !== 32'h0) $display("FAIL rst_epcout got %h exp %h", EPCOut, 32'h0); else pass++;
    tot++; if (NPCOut !== 32'h0) $display("FAIL rst_npc got %h exp %h", NPCOut, 32'h0); else pass++;
    rd(5'd15); tot++; if (DOut !== 32'h2023_0707) $display("FAIL rst_prid got %h exp %h", DOut, 32'h2023_0707); else pass++;
    rd(5'd3); tot++; if (DOut !== 32'h0) $display("FAIL other_reg got %h exp %h", DOut, 32'h0); else pass++;
    reset = 1'b1; step();
  endtask

  task automatic test_interrupt();
    WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_FC01; step();
    WE = 1'b0; HWInt = 6'b000100; VPC = 32'h3010; #1;
    tot++; if (Req !== 1'b1) $display("FAIL int_req got %b exp 1", Req); else pass++;
    tot++; if (NPCOut !== 32'h4180) $display("FAIL int_npc got %h exp %h", NPCOut, 32'h4180); else pass++;
    step(); HWInt = 6'b0;
    rd(5'd14); tot++; if (DOut !== 32'h3010) $display("FAIL int_epc got %h exp %h", DOut, 32'h3010); else pass++;
    rd(5'd13); tot++; if (DOut !== 32'h0000_1000) $display("FAIL int_cause got %h exp %h", DOut, 32'h1000); else pass++;
    rd(5'd12); tot++; if (DOut !== 32'h0000_FC03) $display("FAIL int_sr got %h exp %h", DOut, 32'hFC03); else pass++;
    HWInt = 6'b000100; #1;
    tot++; if (Req !== 1'b0) $display("FAIL int_nested got %b exp 0", Req); else pass++;
    HWInt = 6'b0; EXLClr = 1'b1; step(); EXLClr = 1'b0;
    rd(5'd12); tot++; if (DOut !== 32'h0000_FC01) $display("FAIL eret_sr got %h exp %h", DOut, 32'hFC01); else pass++;
  endtask

  task automatic test_delay_slot();
    ExcCodeIn = 5'd10; BDIn = 1'b1; VPC = 32'h3024; #1;
    tot++; if (Req !== 1'b1) $display("FAIL ds_req got %b exp 1", Req); else pass++;
    step(); ExcCodeIn = 5'd0; BDIn = 1'b0;
    rd(5'd14); tot++; if (DOut !== 32'h3020) $display("FAIL ds_epc got %h exp %h", DOut, 32'h3020); else pass++;
    rd(5'd13); tot++; if (DOut !== 32'h8000_0028) $display("FAIL ds_cause got %h exp %h", DOut, 32'h8000_0028); else pass++;
    EXLClr = 1'b1; step(); EXLClr = 1'b0;
  endtask

  task automatic test_simultaneous();
    HWInt = 6'b000001; ExcCodeIn = 5'd12; VPC = 32'h3040; #1;
    tot++; if (Req !== 1'b1) $display("FAIL sim_req got %b exp 1", Req); else pass++;
    step(); HWInt = 6'b0; ExcCodeIn = 5'd8; VPC = 32'h3050; #1;
    tot++; if (Req !== 1'b0) $display("FAIL nest_req got %b exp 0", Req); else pass++;
    rd(5'd13); tot++; if (DOut !== 32'h0000_0400) $display("FAIL sim_cause got %h exp %h", DOut, 32'h400); else pass++;
    step(); ExcCodeIn = 5'd0;
    rd(5'd14); tot++; if (DOut !== 32'h3040) $display("FAIL nest_epc got %h exp %h", DOut, 32'h3040); else pass++;
    rd(5'd13); tot++; if (DOut !== 32'h0) $display("FAIL nest_cause got %h exp %h", DOut, 32'h0); else pass++;
  endtask

  task automatic test_eret_bypass();
    WE = 1'b1; A2 = 5'd14; DIn = 32'h3100; EXLClr = 1'b1; rd(5'd14);
    tot++; if (EPCOut !== 32'h3100) $display("FAIL byp_epcout got %h exp %h", EPCOut, 32'h3100); else pass++;
    tot++; if (DOut !== 32'h3040) $display("FAIL byp_dout got %h exp %h", DOut, 32'h3040); else pass++;
    step(); WE = 1'b0; EXLClr = 1'b0;
    rd(5'd12); tot++; if (DOut !== 32'h0000_FC01) $display("FAIL eret_exl got %h exp %h", DOut, 32'hFC01); else pass++;
    rd(5'd14); tot++; if (DOut !== 32'h3100) $display("FAIL mtc0_epc got %h exp %h", DOut, 32'h3100); else pass++;
    WE = 1'b1; A2 = 5'd13; DIn = 32'hFFFF_FFFF; step(); WE = 1'b0;
    rd(5'd13); tot++; if (DOut !== 32'h0) $display("FAIL cause_ro got %h exp %h", DOut, 32'h0); else pass++;
    WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_FC03; EXLClr = 1'b1; step(); WE = 1'b0; EXLClr = 1'b0;
    rd(5'd12); tot++; if (DOut !== 32'h0000_FC01) $display("FAIL exlclr_wins got %h exp %h", DOut, 32'hFC01); else pass++;
  endtask

  task automatic test_write_suppress();
    ExcCodeIn = 5'd4; WE = 1'b1; A2 = 5'd12; DIn = 32'h0; VPC = 32'h3060; #1;
    tot++; if (Req !== 1'b1) $display("FAIL sup_req got %b exp 1", Req); else pass++;
    tot++; if (NPCOut !== 32'h4180) $display("FAIL sup_npc got %h exp %h", NPCOut, 32'h4180); else pass++;
    step(); WE = 1'b0; ExcCodeIn = 5'd0;
    rd(5'd12); tot++; if (DOut !== 32'h0000_FC03) $display("FAIL sup_sr got %h exp %h", DOut, 32'hFC03); else pass++;
    rd(5'd13); tot++; if (DOut !== 32'h0000_0010) $display("FAIL sup_cause got %h exp %h", DOut, 32'h10); else pass++;
    rd(5'd14); tot++; if (DOut !== 32'h3060) $display("FAIL sup_epc got %h exp %h", DOut, 32'h3060); else pass++;
    tot++; if (NPCOut !== 32'h3060) $display("FAIL eret_npc got %h exp %h", NPCOut, 32'h3060); else pass++;
  endtask

  task automatic test_reset_mid();
    reset = 1'b0; step(); reset = 1'b1;
    rd(5'd12); tot++; if (DOut !== 32'h0) $display("FAIL midrst_sr got %h exp %h", DOut, 32'h0); else pass++;
    HWInt = 6'b111111; #1;
    tot++; if (Req !== 1'b0) $display("FAIL midrst_mask got %b exp 0", Req); else pass++;
    step(); HWInt = 6'b0;
    rd(5'd13); tot++; if (DOut !== 32'h0000_FC00) $display("FAIL midrst_ip got %h exp %h", DOut, 32'hFC00); else pass++;
  endtask

  initial begin
    step();
    test_reset();
    test_interrupt();
    test_delay_slot();
    test_simultaneous();
    test_eret_bypass();
    test_write_suppress();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, tot);
    $finish;
  end
endmodule
